fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage: owns the program counter, issues word requests to instruction memory over a request/response handshake, and buffers returned instructions in a 2-entry skid buffer. It feeds the IF/ID pipeline register directly (its `Inst`, `PC`, `PC_plus_4` outputs drive that register's inputs of the same names). It accepts stall from the hazard unit and redirect from branch/jump resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  downstream not accepting; head entry held
- `redirect`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  32  new fetch address, valid with `redirect`
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  request word address
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  response instruction word
- `Inst`  out  32  buffered instruction (head entry)
- `PC`  out  32  address of `Inst`
- `PC_plus_4`  out  32  `PC` + 4
- `valid`  out  1  head entry present; 0 = bubble
- `misalign`  out  1  head entry is a misaligned-fetch marker (only with `FETCH_MISALIGN_EN`)

## Operation
- FSM states: S_REQ, S_WAIT, S_DRAIN, S_HALT (S_HALT only with macro).
- S_REQ: `imem_req`=1 iff buffer count + 0 outstanding < 2; `imem_addr`=pc. On `imem_ready`&&`imem_req`: latch req_pc=pc, go S_WAIT.
- S_WAIT: `imem_req`=0. On `imem_rvalid`: push {imem_rdata, req_pc}; pc <= req_pc+4; go S_REQ.
- At most one outstanding request.
- S_DRAIN: wait for the one stale response, discard it, go S_REQ.
- Pop: head consumed when `valid`&&!`stall`. Push and pop in same cycle: count unchanged, order preserved.
- Redirect (priority over stall and over push): buffer cleared, pc <= redirect_pc. If a request is outstanding (S_WAIT, or S_REQ with handshake completing this cycle) go S_DRAIN, else S_REQ. A response arriving in the redirect cycle is discarded.
- `imem_rvalid` in S_REQ or S_HALT is ignored.
- Arithmetic: all PC sums modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- `PC_plus_4` derived from stored PC of head entry.

## Timing
- During `rst`: pc=RESET_PC, state S_REQ, buffer empty; `valid`=0, `imem_req`=0, `Inst`/`PC`/`PC_plus_4`/`misalign`=0.
- First cycle after `rst` low: `imem_req`=1, `imem_addr`=RESET_PC.
- Zero-wait memory (ready same cycle, rvalid next): request cycle N, response N+1, `valid`=1 at N+2. Peak throughput 1 instruction / 2 cycles.
- Redirect in cycle N with nothing outstanding: request to redirect_pc at N+1; `valid`=0 at N+1.
- Reset mid-operation: state cleared immediately; memory shares `rst`, so no stale response is expected.

## Configuration
- `FETCH_MISALIGN_EN` defined: redirect with `redirect_pc[1:0]`!=0 pushes one entry {Inst=32'h0000_0013 (NOP), PC=redirect_pc, misalign=1}, enters S_HALT, issues no requests until the next redirect.
- Undefined: `redirect_pc[1:0]` forced to 2'b00; `misalign` port and S_HALT absent.

## Structure
- Package `fetch_pkg`: FSM state enum, `NOP_INST` = 32'h0000_0013, entry struct {inst, pc, misalign}.
- Sub-module `fetch_skid_buf`: 2-entry FIFO with push/pop/flush, count, head outputs; combinational head, registered storage.

## Test plan
- Reset: `rst`=1 for 3 cycles, RESET_PC=0x100 -> `imem_req`=0, `valid`=0 throughout; next cycle `imem_req`=1, `imem_addr`=0x100.
- Stream, zero-wait memory, rdata=addr^32'hA5A5_A5A5 -> `valid` pulses with PC 0x100, 0x104, 0x108, matching `Inst`, `PC_plus_4`=PC+4, every 2 cycles.
- Hold `stall`=1 for 8 cycles -> buffer holds 0x100/0x104, `imem_req` drops, outputs stable; release -> 0x100 then 0x104 then 0x108, no loss or duplicate.
- Redirect to 0x200 while in S_WAIT -> next response discarded, next `imem_addr`=0x200, first valid PC=0x200.
- Redirect to 0xFFFF_FFFC -> `PC_plus_4`=0, following request `imem_addr`=0x0.
- With `FETCH_MISALIGN_EN`: redirect to 0x202 -> `valid`=1, `misalign`=1, `Inst`=0x0000_0013, no `imem_req` until redirect to 0x300, then fetch 0x300.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, skid-buffer entry, NOP encoding.
// S_HALT exists only when FETCH_MISALIGN_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
`ifdef FETCH_MISALIGN_EN
    , S_HALT
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misalign;
  } fetch_entry_t;

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order FIFO holding fetched instructions; head is combinational from storage.
// Flush wins over pop; a push alongside a flush lands as the sole entry.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output logic         head_vld_o,
  output fetch_entry_t head_dat_o
);

  fetch_entry_t mem_q [2];
  logic [1:0]   count_q;
  logic         pop_ok;
  logic         push_ok;
  logic         wr_idx;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  // Entry 0 is always the head, so the write slot is the post-pop occupancy.
  assign wr_idx  = count_q[0] ^ pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= {1'b0, push_i};
    end else begin
      count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (flush_i) begin
      if (push_i) mem_q[0] <= push_dat_i;
    end else begin
      if (pop_ok)  mem_q[0]      <= mem_q[1];
      if (push_ok) mem_q[wr_idx] <= push_dat_i;
    end
  end

  assign count_o    = count_q;
  assign head_vld_o = (count_q != 2'd0);
  assign head_dat_o = mem_q[0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, single-outstanding imem request/response, 2-entry skid buffer.
// FETCH_MISALIGN_EN: misaligned redirect yields a NOP marker entry and halts fetch until redirected.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        misalign
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  tgt_pc;
  logic         hs;
  logic         in_flight;
  logic         push, pop, flush;
  fetch_entry_t push_dat;
  fetch_entry_t head;
  logic         head_vld;
  logic [1:0]   count;

`ifdef FETCH_MISALIGN_EN
  assign tgt_pc = redirect_pc;
`else
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[1:0];
  assign tgt_pc        = {redirect_pc[31:2], 2'b00};
`endif

  assign imem_req  = !rst && (state_q == S_REQ) && (count != 2'd2);
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_ready;

  assign valid     = !rst && head_vld;
  assign pop       = valid && !stall;
  assign Inst      = valid ? head.inst : '0;
  assign PC        = valid ? head.pc : '0;
  assign PC_plus_4 = valid ? pc_inc(head.pc) : '0;

`ifdef FETCH_MISALIGN_EN
  assign misalign = valid && head.misalign;
`else
  logic unused_misalign;
  assign unused_misalign = head.misalign;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    push      = 1'b0;
    push_dat  = '0;
    flush     = 1'b0;
    in_flight = 1'b0;

    case (state_q)
      S_REQ: begin
        if (hs) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push     = 1'b1;
          push_dat = '{inst: imem_rdata, pc: req_pc_q, misalign: 1'b0};
          pc_d     = pc_inc(req_pc_q);
          state_d  = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: ;
    endcase

    // A response landing in the redirect cycle is dropped, and it also retires the in-flight request.
    if (redirect) begin
      flush     = 1'b1;
      push      = 1'b0;
      push_dat  = '0;
      pc_d      = tgt_pc;
      in_flight = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid) || hs;
      state_d   = in_flight ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_EN
      if (tgt_pc[1:0] != 2'b00) begin
        push     = 1'b1;
        push_dat = '{inst: NOP_INST, pc: tgt_pc, misalign: 1'b1};
        state_d  = S_HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (flush),
    .count_o    (count),
    .head_vld_o (head_vld),
    .head_dat_o (head)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage; memory returns addr ^ A5A5_A5A5 with variable latency.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Inst, PC, PC_plus_4;
  logic        valid;
`ifdef FETCH_MISALIGN_EN
  logic        misalign;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: next address the stage should request, next PC the consumer should see.
  logic [31:0] fetch_exp, cons_exp, mem_addr;
  bit          mem_busy;
  int          mem_cnt, lat_min, lat_max, ready_pct, pops;
  bit          model_en;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Inst        (Inst),
    .PC          (PC),
    .PC_plus_4   (PC_plus_4),
    .valid       (valid)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign    (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applied just before each rising edge, using this cycle's inputs and outputs.
  task automatic model_commit();
    logic [31:0] tgt;
    if (rst) begin
      mem_busy  = 1'b0;
      fetch_exp = RPC;
      cons_exp  = RPC;
      return;
    end
    if (model_en && valid) begin
      chk("head_pc", PC, cons_exp);
      chk("head_inst", Inst, cons_exp ^ KEY);
      chk("head_pc4", PC_plus_4, cons_exp + 32'd4);
    end
    if (imem_req && imem_ready) begin
      if (model_en) begin
        chk("one_outstanding", {31'b0, mem_busy}, 32'd0);
        chk("fetch_addr", imem_addr, fetch_exp);
      end
      mem_busy  = 1'b1;
      mem_cnt   = $urandom_range(lat_max, lat_min);
      mem_addr  = imem_addr;
      fetch_exp = fetch_exp + 32'd4;
    end
    if (redirect) begin
      tgt = redirect_pc;
`ifndef FETCH_MISALIGN_EN
      tgt[1:0] = 2'b00;
`endif
      fetch_exp = tgt;
      cons_exp  = tgt;
    end else if (valid && !stall) begin
      cons_exp = cons_exp + 32'd4;
      pops++;
    end
  endtask

  task automatic mem_drive();
    if (rst || !mem_busy) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end else if (mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr ^ KEY;
      mem_busy    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      mem_cnt--;
    end
    imem_ready = ($urandom_range(99, 0) < ready_pct);
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  initial begin
    int n;
    lat_min = 0; lat_max = 0; ready_pct = 100; model_en = 1'b1; pops = 0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; fetch_exp = RPC; cons_exp = RPC;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", imem_req, 0);
      chk("rst_valid", valid, 0);
      chk("rst_pc", PC, 0);
      chk("rst_inst", Inst, 0);
    end
    rst = 1'b0;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RPC);

    // Zero-wait stream: one instruction every two cycles
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_valid", valid, 32'(i % 2));
      if (i % 2 == 1) begin
        chk("stream_pc", PC, RPC + 32'(4 * (i / 2)));
        chk("stream_inst", Inst, (RPC + 32'(4 * (i / 2))) ^ KEY);
        chk("stream_pc4", PC_plus_4, RPC + 32'(4 * (i / 2)) + 32'd4);
      end
    end

    stall = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("stall_valid", valid, 1);
      chk("stall_pc", PC, 32'h108);
      if (i >= 2) chk("stall_req_drop", imem_req, 0);
    end
    stall = 1'b0;
    chk("release_pc0", PC, 32'h108);
    tick();
    chk("release_v1", valid, 1);
    chk("release_pc1", PC, 32'h10C);
    chk("release_req", imem_req, 1);
    chk("release_addr", imem_addr, 32'h110);
    tick();
    chk("release_gap", valid, 0);
    tick();
    chk("release_v2", valid, 1);
    chk("release_pc2", PC, 32'h110);

    // Redirect while a slow response is still in flight
    lat_min = 2; lat_max = 2;
    tick();
    chk("wait_req_low", imem_req, 0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("redir_flush", valid, 0);
    lat_min = 0; lat_max = 0;
    n = 0;
    while (!imem_req && n < 10) begin
      tick();
      chk("drain_valid", valid, 0);
      n++;
    end
    chk("redir_req_seen", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h200);
    n = 0;
    while (!valid && n < 10) begin
      tick();
      n++;
    end
    chk("redir_valid", valid, 1);
    chk("redir_first_pc", PC, 32'h200);

    // Redirect with nothing outstanding, onto the wrap boundary
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("nr_valid", valid, 0);
    chk("nr_req", imem_req, 1);
    chk("nr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_valid", valid, 1);
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", PC_plus_4, 32'h0);
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ignore_rvalid", valid, 0);
    tick();
    chk("after_wrap_pc", PC, 32'h0);

`ifdef FETCH_MISALIGN_EN
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h202;
    tick();
    model_en = 1'b0;
    redirect = 1'b0;
    chk("mis_valid", valid, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_inst", Inst, 32'h0000_0013);
    chk("mis_pc", PC, 32'h202);
    for (int i = 0; i < 4; i++) begin
      chk("halt_req", imem_req, 0);
      tick();
    end
    chk("halt_empty", valid, 0);
    model_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    chk("unhalt_req", imem_req, 1);
    chk("unhalt_addr", imem_addr, 32'h300);
`endif

    // Random traffic against the reference model
    lat_min = 0; lat_max = 3; ready_pct = 60; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(99, 0) < 30);
      redirect    = ($urandom_range(99, 0) < 4);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                                 : $urandom;
`ifdef FETCH_MISALIGN_EN
      redirect_pc[1:0] = 2'b00;
`endif
      tick();
    end
    redirect = 1'b0;
    stall    = 1'b0;
    chk("progress", {31'b0, (pops > 200)}, 1);

    rst = 1'b1;
    tick();
    chk("midrst_valid", valid, 0);
    chk("midrst_req", imem_req, 0);
    rst = 1'b0;
    #1;
    chk("midrst_req1", imem_req, 1);
    chk("midrst_addr", imem_addr, RPC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
